// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: field-level descriptors in, 32-bit machine
// words tagged with sequential word addresses out through a small FIFO.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]     DEPTH_C  = (PW+1)'(DEPTH);
    localparam logic [PW:0]     CNT_ZERO = (PW+1)'(0);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [3:0] MNEM_LAST_WORD = 4'd13;
    localparam logic [3:0] MNEM_HALT      = 4'd14;
    localparam logic [3:0] MNEM_ILLEGAL   = 4'd15;

    logic [1:0]        stateR;
    logic [31:0]       wordMemR [DEPTH];
    logic [ADDR_W-1:0] addrMemR [DEPTH];
    logic [PW-1:0]     wrPtrR;
    logic [PW-1:0]     rdPtrR;
    logic [PW:0]       countR;
    logic [ADDR_W-1:0] addrCntR;
    logic              errR;

    logic acceptS;
    logic pushS;
    logic popS;
    logic fifoFullS;
    logic fifoEmptyS;
    logic [31:0] encWordS;

    // Field packing; shift-type R-ops zero rs, other R-ops zero shamt.
    function automatic logic [31:0] encodeWord(
        input logic [3:0]  m,
        input logic [4:0]  rsF,
        input logic [4:0]  rtF,
        input logic [4:0]  rdF,
        input logic [4:0]  shF,
        input logic [15:0] immF
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (m)
            4'd0:    w = {6'b000000, rsF, rtF, rdF, 5'd0, 6'b100000};
            4'd1:    w = {6'b000000, rsF, rtF, rdF, 5'd0, 6'b100010};
            4'd2:    w = {6'b000000, 5'd0, rtF, rdF, shF, 6'b000000};
            4'd3:    w = {6'b000000, 5'd0, rtF, rdF, shF, 6'b000010};
            4'd4:    w = {6'b000000, rsF, rtF, rdF, 5'd0, 6'b100100};
            4'd5:    w = {6'b000000, rsF, rtF, rdF, 5'd0, 6'b100101};
            4'd6:    w = {6'b000000, rsF, rtF, rdF, 5'd0, 6'b101010};
            4'd7:    w = {6'b000100, rsF, rtF, immF};
            4'd8:    w = {6'b001000, rsF, rtF, immF};
            4'd9:    w = {6'b100011, rsF, rtF, immF};
            4'd10:   w = {6'b101011, rsF, rtF, immF};
            4'd11:   w = {6'b100001, rsF, rtF, immF};
            4'd12:   w = {6'b001100, rsF, rtF, immF};
            4'd13:   w = {6'b001101, rsF, rtF, immF};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Handshake qualification; fullness is judged before any same-cycle pop.
    always_comb begin
        fifoFullS  = (countR == DEPTH_C);
        fifoEmptyS = (countR == CNT_ZERO);
        in_ready   = (stateR == RUN) && !fifoFullS;
        acceptS    = in_valid && in_ready;
        pushS      = acceptS && (mnem <= MNEM_LAST_WORD);
        out_valid  = !fifoEmptyS;
        popS       = out_valid && out_ready;
        encWordS   = encodeWord(mnem, rs, rt, rd, shamt, imm);
        done       = (stateR == FLUSH) && fifoEmptyS;
        err        = errR;
        if (out_valid) begin
            out_word = wordMemR[rdPtrR];
            out_addr = addrMemR[rdPtrR];
        end else begin
            out_word = 32'h0000_0000;
            out_addr = '0;
        end
    end

    // Program sequencing, sticky illegal flag and word-address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR   <= IDLE;
            addrCntR <= '0;
            errR     <= 1'b0;
        end else begin
            case (stateR)
                IDLE: begin
                    if (start) begin
                        stateR   <= RUN;
                        addrCntR <= '0;
                        errR     <= 1'b0;
                    end
                end
                RUN: begin
                    if (acceptS && (mnem == MNEM_HALT)) begin
                        stateR <= FLUSH;
                    end
                    if (acceptS && (mnem == MNEM_ILLEGAL)) begin
                        errR <= 1'b1;
                    end
                    if (pushS) begin
                        addrCntR <= addrCntR + ADDR_ONE;
                    end
                end
                FLUSH: begin
                    if (fifoEmptyS) begin
                        stateR <= IDLE;
                    end
                end
                default: stateR <= IDLE;
            endcase
        end
    end

    // FIFO storage; entries cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                wordMemR[i] <= 32'h0000_0000;
                addrMemR[i] <= '0;
            end
        end else if (pushS) begin
            wordMemR[wrPtrR] <= encWordS;
            addrMemR[wrPtrR] <= addrCntR;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrR <= '0;
            rdPtrR <= '0;
            countR <= '0;
        end else begin
            if (pushS) begin
                wrPtrR <= wrPtrR + PTR_ONE;
            end
            if (popS) begin
                rdPtrR <= rdPtrR + PTR_ONE;
            end
            countR <= countR + (PW+1)'(pushS) - (PW+1)'(popS);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encoding table, hand-written handshake
// sequences and random traffic checked against a queue-based reference model.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int ADDR_W = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, out_valid, out_ready, err, done;
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] out_word;
    logic [ADDR_W-1:0] out_addr;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [39:0] expQ [$];
    int  mode = M_IDLE;
    int  mCnt = 0;
    bit  mErr = 1'b0;
    bit  lastAcc = 1'b0;
    int  doneSeen = 0;

    int opTab [16] = '{0, 0, 0, 0, 0, 0, 0, 4, 8, 35, 43, 33, 12, 13, 0, 0};
    int fnTab [16] = '{32, 34, 0, 2, 36, 37, 42, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    typedef struct {
        logic [3:0]  m;
        logic [4:0]  a, b, c, s;
        logic [15:0] im;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=completion", name);
    endtask

    function automatic logic [31:0] refWord(int m, int a, int b, int c, int s, int im);
        longint v;
        if (m < 7) begin
            if (m == 2 || m == 3) a = 0;
            else s = 0;
            v = a * (2**21) + b * (2**16) + c * (2**11) + s * 64 + fnTab[m];
        end else begin
            v = longint'(opTab[m]) * (2**26) + a * (2**21) + b * (2**16) + im;
        end
        return v[31:0];
    endfunction

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic step(input bit r, input bit st, input bit iv, input logic [3:0] m,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic [4:0] s, input logic [15:0] im, input bit ordy);
        bit expReady, popNow;
        logic [39:0] head;
        rst = r; start = st; in_valid = iv; mnem = m;
        rs = a; rt = b; rd = c; shamt = s; imm = im; out_ready = ordy;
        #1;
        expReady = (mode == M_RUN) && (expQ.size() < DEPTH);
        check("in_ready", in_ready, expReady);
        check("out_valid", out_valid, expQ.size() != 0);
        check("err", err, mErr);
        check("done", done, (mode == M_FLUSH) && (expQ.size() == 0));
        if (expQ.size() != 0) begin
            head = expQ[0];
            check("out_word", out_word, head[39:8]);
            check("out_addr", out_addr, head[7:0]);
        end
        if (done === 1'b1) doneSeen++;
        lastAcc = iv && expReady;
        if (r) begin
            expQ.delete();
            mode = M_IDLE; mCnt = 0; mErr = 1'b0; lastAcc = 1'b0;
        end else begin
            popNow = (expQ.size() != 0) && ordy;
            if (mode == M_IDLE && st) begin
                mode = M_RUN; mCnt = 0; mErr = 1'b0;
            end else if (mode == M_FLUSH && expQ.size() == 0) begin
                mode = M_IDLE;
            end
            if (popNow) void'(expQ.pop_front());
            if (lastAcc) begin
                if (m <= 13) begin
                    expQ.push_back({refWord(m, a, b, c, s, im), 8'(mCnt)});
                    mCnt = (mCnt + 1) % (2**ADDR_W);
                end else if (m == 14) begin
                    mode = M_FLUSH;
                end else begin
                    mErr = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy, input int n);
        repeat (n) step(0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, ordy);
    endtask

    task automatic doStart();
        step(0, 1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
    endtask

    task automatic send(input logic [3:0] m, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] s, input logic [15:0] im,
                        input bit ordy);
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 1, m, a, b, c, s, im, ordy);
            if (lastAcc) return;
        end
        timeoutFail("send_accept");
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 40; k++) begin
            if (mode == M_IDLE) return;
            idle(1'b1, 1);
        end
        timeoutFail("wait_idle");
    endtask

    initial begin
        tbl[0]  = '{4'd0,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0000, 32'h0022_1820};
        tbl[1]  = '{4'd9,  5'd29, 5'd8,  5'd0, 5'd0, 16'h0004, 32'h8FA8_0004};
        tbl[2]  = '{4'd2,  5'd7,  5'd5,  5'd4, 5'd2, 16'h0000, 32'h0005_2080};
        tbl[3]  = '{4'd1,  5'd1,  5'd2,  5'd3, 5'd5, 16'h0000, 32'h0022_1822};
        tbl[4]  = '{4'd3,  5'd9,  5'd3,  5'd2, 5'd4, 16'h0000, 32'h0003_1102};
        tbl[5]  = '{4'd4,  5'd4,  5'd5,  5'd6, 5'd0, 16'h0000, 32'h0085_3024};
        tbl[6]  = '{4'd5,  5'd1,  5'd1,  5'd1, 5'd0, 16'h0000, 32'h0021_0825};
        tbl[7]  = '{4'd6,  5'd2,  5'd3,  5'd4, 5'd0, 16'h0000, 32'h0043_202A};
        tbl[8]  = '{4'd7,  5'd1,  5'd2,  5'd0, 5'd0, 16'hFFFF, 32'h1022_FFFF};
        tbl[9]  = '{4'd8,  5'd0,  5'd8,  5'd0, 5'd0, 16'h0005, 32'h2008_0005};
        tbl[10] = '{4'd10, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 32'hAFBF_0008};
        tbl[11] = '{4'd11, 5'd3,  5'd4,  5'd0, 5'd0, 16'h1234, 32'h8464_1234};
        tbl[12] = '{4'd12, 5'd1,  5'd2,  5'd7, 5'd3, 16'h00FF, 32'h3022_00FF};
        tbl[13] = '{4'd13, 5'd5,  5'd6,  5'd0, 5'd0, 16'h8000, 32'h34A6_8000};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mnem = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; imm = 16'h0;
        repeat (2) @(negedge clk);
        step(1, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
        check("reset_word", out_word, 32'h0);
        check("reset_addr", out_addr, 8'h0);
        idle(1'b0, 1);

        // encoding table: each word must reach the head one cycle after accept
        doStart();
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].im, 1'b1);
            check("tbl_word", out_word, tbl[i].exp);
            check("tbl_addr", out_addr, 8'(i));
        end
        send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
        waitIdle();

        // backpressure: four fill the FIFO, the fifth waits for a pop
        doStart();
        for (int i = 0; i < 4; i++) send(4'd8, 5'(i), 5'd1, 5'd0, 5'd0, 16'(i), 1'b0);
        check("bp_full", in_ready, 1'b0);
        idle(1'b0, 2);
        send(4'd8, 5'd4, 5'd1, 5'd0, 5'd0, 16'd4, 1'b1);
        idle(1'b1, 6);
        check("bp_drained", out_valid, 1'b0);
        send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
        waitIdle();

        // illegal descriptor between two ORI
        doStart();
        send(4'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00AA, 1'b1);
        send(4'd15, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1111, 1'b1);
        send(4'd13, 5'd4, 5'd5, 5'd0, 5'd0, 16'h00BB, 1'b1);
        check("ill_addr", out_addr, 8'd1);
        idle(1'b1, 3);
        check("ill_err", err, 1'b1);
        send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
        waitIdle();
        check("ill_err_idle", err, 1'b1);
        doStart();
        check("ill_err_clr", err, 1'b0);

        // HALT with pending words: done only once the FIFO drains
        send(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'd1, 1'b0);
        send(4'd8, 5'd3, 5'd4, 5'd0, 5'd0, 16'd2, 1'b0);
        send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
        doneSeen = 0;
        idle(1'b0, 5);
        check("halt_no_done", doneSeen, 0);
        waitIdle();
        check("halt_done_once", doneSeen, 1);

        // address wrap after 256 words
        doStart();
        for (int i = 0; i < 257; i++) send(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i), 1'b1);
        check("wrap_addr", out_addr, 8'd0);
        check("wrap_word", out_word, 32'h3022_0100);
        send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
        waitIdle();

        // reset mid-stream discards buffered words
        doStart();
        for (int i = 0; i < 3; i++) send(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i), 1'b0);
        step(1, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        doStart();
        send(4'd8, 5'd2, 5'd3, 5'd0, 5'd0, 16'd9, 1'b1);
        check("rst_addr", out_addr, 8'd0);
        idle(1'b1, 2);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(199) == 0), ($urandom_range(5) == 0), $urandom_range(1),
                 4'($urandom_range(15)), 5'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 16'($urandom), ($urandom_range(3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
